// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Brief    : Instruction-fetch stage. Issues one imem request at a time at
//            the current PC, tags returned instructions with their PC in a
//            small FIFO and presents them to decode with stall/flush control.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
  parameter int          DEPTH = 2,
  parameter logic [31:0] NOP   = 32'h00000013
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] pc,
  output logic        PcEnable,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        Flush,
  input  logic        Stall,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr
);

  localparam int c_aw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_cw = $clog2(DEPTH + 1);

  // Queue storage and bookkeeping
  logic [31:0]     r_pc_mem    [DEPTH];
  logic [31:0]     r_instr_mem [DEPTH];
  logic [c_aw-1:0] r_head;
  logic [c_aw-1:0] r_tail;
  logic [c_cw-1:0] r_count;

  // Single in-flight request tracking
  logic            r_out;
  logic            r_discard;
  logic [31:0]     r_out_pc;

  logic            w_deq;
  logic            w_enq;
  logic            w_grant;
  logic            w_credit;
  logic [c_cw:0]   w_occupancy;

  // Credit accounting: entries held plus the one that may still land, minus
  // the one leaving this cycle, must leave room for a fresh response.
  always_comb begin
    w_occupancy = {1'b0, r_count} + (c_cw + 1)'(r_out) - (c_cw + 1)'(w_deq);
    w_credit    = (w_occupancy < (c_cw + 1)'(DEPTH));
  end

  // Request, grant and queue-handshake decode
  always_comb begin
    id_valid  = (r_count != '0);
    w_deq     = id_valid & ~Stall;
    imem_req  = ~Reset & ~Flush & (~r_out | imem_rvalid) & w_credit;
    imem_addr = pc;
    w_grant   = imem_req & imem_gnt;
    PcEnable  = w_grant;
    w_enq     = imem_rvalid & r_out & ~r_discard & ~Flush;
  end

  // Head entry presented to decode; NOP bubble when empty
  always_comb begin
    id_pc    = 32'h0;
    id_instr = NOP;
    if (id_valid) begin
      id_pc    = r_pc_mem[r_head];
      id_instr = r_instr_mem[r_head];
    end
  end

  // Queue data write at the tail; contents are only observable through count
  always_ff @(posedge Clk) begin
    if (w_enq) begin
      r_pc_mem[r_tail]    <= r_out_pc;
      r_instr_mem[r_tail] <= imem_rdata;
    end
  end

  // Queue pointers and occupancy; flush empties the queue outright
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (Flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) r_tail <= r_tail + c_aw'(1);
      if (w_deq) r_head <= r_head + c_aw'(1);
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + c_cw'(1);
        2'b01:   r_count <= r_count - c_cw'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Outstanding request, its PC tag, and the drop-late-response flag
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_out     <= 1'b0;
      r_out_pc  <= 32'h0;
      r_discard <= 1'b0;
    end else begin
      // A grant never coincides with Flush because imem_req is gated by it
      if (w_grant) begin
        r_out    <= 1'b1;
        r_out_pc <= pc;
      end else if (imem_rvalid) begin
        r_out    <= 1'b0;
      end
      // The response for a flushed request is still owed by memory; remember
      // to swallow it unless it is arriving right now
      if (imem_rvalid && r_out)
        r_discard <= 1'b0;
      else if (Flush && r_out)
        r_discard <= 1'b1;
    end
  end

endmodule
`default_nettype wire
